// File: rtl/commit_stage.sv
`default_nettype none
// ============================================================================
// Module      : commit_stage
// Description : In-order retirement stage fed by the ROB head entry. Retires
//               ALU results to the architectural register file, performs
//               stores through a req/ack handshake, raises a one-cycle flush
//               with a redirect PC on mispredicts, and stops on halt.
// Revision    : 1.0 - initial release
// ============================================================================
module commit_stage #(
  parameter int ROBsize  = 16,
  parameter int addrSize = $clog2(ROBsize),
  parameter int cntWidth = 32
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                robEmpty_i,
  input  logic [addrSize:0]   head_i,
  input  logic [78:0]         commitEntry_i,
  input  logic [63:0]         commitExtra_i,
  output logic                updateHead_o,
  output logic                rfWriteEn_o,
  output logic [4:0]          rfWriteAddr_o,
  output logic [63:0]         rfWriteData_o,
  output logic                memReq_o,
  output logic [63:0]         memAddr_o,
  output logic [63:0]         memData_o,
  input  logic                memAck_i,
  output logic                flush_o,
  output logic [63:0]         redirectPc_o,
  output logic [addrSize:0]   retireTag_o,
  output logic                halted_o,
  output logic [cntWidth-1:0] commitCount_o
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_STORE  = 2'd1,
    S_FLUSH  = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  // Head entry field decode
  logic [63:0] w_result;
  logic [4:0]  w_dest;
  logic        w_regWrite;
  logic        w_isStore;
  logic        w_mispredict;
  logic        w_halt;
  logic        w_complete;
  logic        w_ready;
  logic        w_destWritable;

  assign w_result       = commitEntry_i[63:0];
  assign w_dest         = commitEntry_i[68:64];
  assign w_regWrite     = commitEntry_i[69];
  assign w_isStore      = commitEntry_i[70];
  assign w_mispredict   = commitEntry_i[71];
  assign w_halt         = commitEntry_i[72];
  assign w_complete     = commitEntry_i[73];
  assign w_ready        = ~robEmpty_i & w_complete;
  // r0 is hardwired to zero, so a write aimed at it is simply dropped
  assign w_destWritable = w_regWrite & (w_dest != 5'd0);

  // Reserved entry bits carry no meaning for retirement
  logic w_unused_reserved;
  assign w_unused_reserved = ^commitEntry_i[78:74];

  // Registered state and outputs
  state_t                state_q, state_d;
  logic                  memReq_q;
  logic [63:0]           memAddr_q;
  logic [63:0]           memData_q;
  logic                  flush_q;
  logic [63:0]           redirectPc_q;
  logic                  halted_q;
  logic [addrSize:0]     retireTag_q;
  logic [cntWidth-1:0]   commitCount_q;

  // Per-cycle decisions
  logic w_retire;
  logic w_rfWe;
  logic w_captureStore;
  logic w_captureRedirect;

  // Next-state and retire decision; reset suppresses every combinational action
  always_comb begin
    state_d           = state_q;
    w_retire          = 1'b0;
    w_rfWe            = 1'b0;
    w_captureStore    = 1'b0;
    w_captureRedirect = 1'b0;
    case (state_q)
      S_RUN: begin
        if (w_ready) begin
          if (w_halt) begin
            w_retire = 1'b1;
            state_d  = S_HALTED;
          end else if (w_isStore) begin
            // Head only advances once memory accepts the store
            w_captureStore = 1'b1;
            state_d        = S_STORE;
          end else if (w_mispredict) begin
            w_retire          = 1'b1;
            w_rfWe            = w_destWritable;
            w_captureRedirect = 1'b1;
            state_d           = S_FLUSH;
          end else begin
            w_retire = 1'b1;
            w_rfWe   = w_destWritable;
          end
        end
      end
      S_STORE: begin
        if (memAck_i) begin
          w_retire = 1'b1;
          state_d  = S_RUN;
        end
      end
      S_FLUSH: begin
        // ROB contents are stale while the flush propagates; never retire here
        state_d = S_RUN;
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
    if (reset_i) begin
      state_d           = S_RUN;
      w_retire          = 1'b0;
      w_rfWe            = 1'b0;
      w_captureStore    = 1'b0;
      w_captureRedirect = 1'b0;
    end
  end

  // State register plus registered handshake, flush, halt and retire bookkeeping
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= S_RUN;
      memReq_q      <= 1'b0;
      memAddr_q     <= '0;
      memData_q     <= '0;
      flush_q       <= 1'b0;
      redirectPc_q  <= '0;
      halted_q      <= 1'b0;
      retireTag_q   <= '0;
      commitCount_q <= '0;
    end else begin
      state_q  <= state_d;
      memReq_q <= (state_d == S_STORE);
      flush_q  <= (state_d == S_FLUSH);
      halted_q <= (state_d == S_HALTED);
      if (w_captureStore) begin
        memAddr_q <= w_result;
        memData_q <= commitExtra_i;
      end
      if (w_captureRedirect) begin
        redirectPc_q <= commitExtra_i;
      end
      if (w_retire) begin
        retireTag_q   <= head_i;
        commitCount_q <= commitCount_q + cntWidth'(1);
      end
    end
  end

  assign updateHead_o  = w_retire;
  assign rfWriteEn_o   = w_rfWe;
  assign rfWriteAddr_o = w_rfWe ? w_dest : 5'd0;
  assign rfWriteData_o = w_rfWe ? w_result : 64'd0;
  assign memReq_o      = memReq_q;
  assign memAddr_o     = memAddr_q;
  assign memData_o     = memData_q;
  assign flush_o       = flush_q;
  assign redirectPc_o  = redirectPc_q;
  assign retireTag_o   = retireTag_q;
  assign halted_o      = halted_q;
  assign commitCount_o = commitCount_q;

endmodule
`default_nettype wire

// File: tb/tb_commit_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_commit_stage
// Description : Self-checking bench for commit_stage: per-cycle vector table
//               run through an expected-value queue, plus hand-written
//               back-to-back retire and store handshake sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_commit_stage;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        robEmpty_i;
  logic [4:0]  head_i;
  logic [78:0] commitEntry_i;
  logic [63:0] commitExtra_i;
  logic        memAck_i;
  logic        updateHead_o, rfWriteEn_o, memReq_o, flush_o, halted_o;
  logic [4:0]  rfWriteAddr_o, retireTag_o;
  logic [63:0] rfWriteData_o, memAddr_o, memData_o, redirectPc_o;
  logic [31:0] commitCount_o;

  commit_stage #(.ROBsize(16), .cntWidth(32)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .robEmpty_i(robEmpty_i), .head_i(head_i),
    .commitEntry_i(commitEntry_i), .commitExtra_i(commitExtra_i),
    .updateHead_o(updateHead_o), .rfWriteEn_o(rfWriteEn_o),
    .rfWriteAddr_o(rfWriteAddr_o), .rfWriteData_o(rfWriteData_o),
    .memReq_o(memReq_o), .memAddr_o(memAddr_o), .memData_o(memData_o),
    .memAck_i(memAck_i), .flush_o(flush_o), .redirectPc_o(redirectPc_o),
    .retireTag_o(retireTag_o), .halted_o(halted_o), .commitCount_o(commitCount_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rst, emp;
    logic [4:0]  head;
    logic        hl, st, mp, rw, cp;
    logic [4:0]  dest;
    logic [63:0] res, ext;
    logic        ack;
    logic        full;   // compare every field, including don't-care data
    logic        uh, we;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic        mreq;
    logic [63:0] ma, md;
    logic        fl;
    logic [63:0] rpc;
    logic [4:0]  tag;
    logic        hlt;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(
      input logic rst, emp, input logic [4:0] head,
      input logic hl, st, mp, rw, cp, input logic [4:0] dest,
      input logic [63:0] res, ext, input logic ack, full, uh, we,
      input logic [4:0] wa, input logic [63:0] wd, input logic mreq,
      input logic [63:0] ma, md, input logic fl, input logic [63:0] rpc,
      input logic [4:0] tag, input logic hlt, input logic [31:0] cnt);
    vec_t v;
    v.rst = rst; v.emp = emp; v.head = head; v.hl = hl; v.st = st; v.mp = mp;
    v.rw = rw; v.cp = cp; v.dest = dest; v.res = res; v.ext = ext; v.ack = ack;
    v.full = full; v.uh = uh; v.we = we; v.wa = wa; v.wd = wd; v.mreq = mreq;
    v.ma = ma; v.md = md; v.fl = fl; v.rpc = rpc; v.tag = tag; v.hlt = hlt;
    v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rst, emp, input logic [4:0] head,
                       input logic hl, st, mp, rw, cp, input logic [4:0] dest,
                       input logic [63:0] res, ext, input logic ack, input logic [4:0] rsv);
    reset_i       = rst;
    robEmpty_i    = emp;
    head_i        = head;
    commitEntry_i = {rsv, cp, hl, mp, st, rw, dest, res};
    commitExtra_i = ext;
    memAck_i      = ack;
  endtask

  initial begin
    vec_t e;
    logic seen;
    logic [63:0] rv;
    //                rst emp hd  hl st mp rw cp dst res        ext        ack full uh we wa  wd      mreq ma       md        fl rpc       tag hlt cnt
    tbl.push_back(mk(1, 1, 0,  0,0,0,0,0, 0, 64'h0,     64'h0,     0,  1,  0, 0, 0, 64'h0,  0, 64'h0,   64'h0,    0, 64'h0,    0, 0, 0));
    tbl.push_back(mk(1, 0, 1,  0,0,0,1,1, 3, 64'hA,     64'h0,     0,  1,  0, 0, 0, 64'h0,  0, 64'h0,   64'h0,    0, 64'h0,    0, 0, 0));
    tbl.push_back(mk(0, 0, 1,  0,0,0,1,1, 3, 64'hA,     64'h0,     0,  0,  1, 1, 3, 64'hA,  0, 64'h0,   64'h0,    0, 64'h0,    0, 0, 0));
    tbl.push_back(mk(0, 0, 2,  0,0,0,1,1, 4, 64'hB,     64'h0,     0,  0,  1, 1, 4, 64'hB,  0, 64'h0,   64'h0,    0, 64'h0,    1, 0, 1));
    tbl.push_back(mk(0, 0, 3,  0,0,0,1,1, 5, 64'hC,     64'h0,     0,  0,  1, 1, 5, 64'hC,  0, 64'h0,   64'h0,    0, 64'h0,    2, 0, 2));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(0, 0, 4, 0,0,0,1,0, 6, 64'hD,     64'h0,     0,  0,  0, 0, 0, 64'h0,  0, 64'h0,   64'h0,    0, 64'h0,    3, 0, 3));
    tbl.push_back(mk(0, 0, 4,  0,0,0,1,1, 6, 64'hD,     64'h0,     0,  0,  1, 1, 6, 64'hD,  0, 64'h0,   64'h0,    0, 64'h0,    3, 0, 3));
    tbl.push_back(mk(0, 1, 5,  0,0,0,1,1, 7, 64'hE,     64'h0,     0,  0,  0, 0, 0, 64'h0,  0, 64'h0,   64'h0,    0, 64'h0,    4, 0, 4));
    tbl.push_back(mk(0, 0, 5,  0,1,0,1,1, 8, 64'h100,   64'hDEAD,  1,  0,  0, 0, 0, 64'h0,  0, 64'h0,   64'h0,    0, 64'h0,    4, 0, 4));
    tbl.push_back(mk(0, 0, 5,  0,1,0,1,1, 8, 64'h100,   64'hDEAD,  0,  0,  0, 0, 0, 64'h0,  1, 64'h100, 64'hDEAD, 0, 64'h0,    4, 0, 4));
    tbl.push_back(mk(0, 0, 5,  0,1,0,1,1, 8, 64'h200,   64'hBEEF,  0,  0,  0, 0, 0, 64'h0,  1, 64'h100, 64'hDEAD, 0, 64'h0,    4, 0, 4));
    tbl.push_back(mk(0, 0, 5,  0,1,0,1,1, 8, 64'h100,   64'hDEAD,  1,  0,  1, 0, 0, 64'h0,  1, 64'h100, 64'hDEAD, 0, 64'h0,    4, 0, 4));
    tbl.push_back(mk(0, 1, 6,  0,0,0,0,0, 0, 64'h0,     64'h0,     0,  0,  0, 0, 0, 64'h0,  0, 64'h0,   64'h0,    0, 64'h0,    5, 0, 5));
    tbl.push_back(mk(0, 0, 6,  0,0,1,1,1, 1, 64'h55,    64'h4000,  0,  0,  1, 1, 1, 64'h55, 0, 64'h0,   64'h0,    0, 64'h0,    5, 0, 5));
    tbl.push_back(mk(0, 0, 7,  0,0,0,1,1, 2, 64'h77,    64'h0,     0,  0,  0, 0, 0, 64'h0,  0, 64'h0,   64'h0,    1, 64'h4000, 6, 0, 6));
    tbl.push_back(mk(0, 0, 7,  0,0,0,1,1, 2, 64'h77,    64'h0,     0,  0,  1, 1, 2, 64'h77, 0, 64'h0,   64'h0,    0, 64'h0,    6, 0, 6));
    tbl.push_back(mk(0, 0, 8,  0,0,0,1,1, 0, 64'h99,    64'h0,     0,  0,  1, 0, 0, 64'h0,  0, 64'h0,   64'h0,    0, 64'h0,    7, 0, 7));
    tbl.push_back(mk(0, 0, 9,  0,0,1,0,1, 3, 64'h66,    64'h8000,  0,  0,  1, 0, 0, 64'h0,  0, 64'h0,   64'h0,    0, 64'h0,    8, 0, 8));
    tbl.push_back(mk(0, 1, 10, 0,0,0,0,0, 0, 64'h0,     64'h0,     0,  0,  0, 0, 0, 64'h0,  0, 64'h0,   64'h0,    1, 64'h8000, 9, 0, 9));
    tbl.push_back(mk(0, 0, 10, 1,0,0,0,1, 4, 64'h0,     64'h0,     0,  0,  1, 0, 0, 64'h0,  0, 64'h0,   64'h0,    0, 64'h0,    9, 0, 9));
    tbl.push_back(mk(0, 0, 11, 0,0,0,1,1, 5, 64'h11,    64'h0,     0,  0,  0, 0, 0, 64'h0,  0, 64'h0,   64'h0,    0, 64'h0,    10, 1, 10));
    tbl.push_back(mk(0, 0, 11, 0,1,0,0,1, 5, 64'h11,    64'h22,    1,  0,  0, 0, 0, 64'h0,  0, 64'h0,   64'h0,    0, 64'h0,    10, 1, 10));
    tbl.push_back(mk(1, 0, 11, 0,0,0,1,1, 5, 64'h11,    64'h0,     0,  0,  0, 0, 0, 64'h0,  0, 64'h0,   64'h0,    0, 64'h0,    10, 1, 10));
    tbl.push_back(mk(0, 1, 1,  0,0,0,0,0, 0, 64'h0,     64'h0,     0,  0,  0, 0, 0, 64'h0,  0, 64'h0,   64'h0,    0, 64'h0,    0, 0, 0));
    tbl.push_back(mk(0, 0, 1,  0,1,0,0,1, 0, 64'h300,   64'h1234,  0,  0,  0, 0, 0, 64'h0,  0, 64'h0,   64'h0,    0, 64'h0,    0, 0, 0));
    tbl.push_back(mk(0, 0, 1,  0,1,0,0,1, 0, 64'h300,   64'h1234,  0,  0,  0, 0, 0, 64'h0,  1, 64'h300, 64'h1234, 0, 64'h0,    0, 0, 0));
    tbl.push_back(mk(1, 0, 1,  0,1,0,0,1, 0, 64'h300,   64'h1234,  1,  0,  0, 0, 0, 64'h0,  1, 64'h300, 64'h1234, 0, 64'h0,    0, 0, 0));
    tbl.push_back(mk(0, 1, 2,  0,0,0,0,0, 0, 64'h0,     64'h0,     1,  0,  0, 0, 0, 64'h0,  0, 64'h0,   64'h0,    0, 64'h0,    0, 0, 0));
    tbl.push_back(mk(0, 0, 2,  0,0,0,1,1, 9, 64'h42,    64'h0,     0,  0,  1, 1, 9, 64'h42, 0, 64'h0,   64'h0,    0, 64'h0,    0, 0, 0));
    tbl.push_back(mk(0, 1, 3,  0,0,0,0,0, 0, 64'h0,     64'h0,     0,  0,  0, 0, 0, 64'h0,  0, 64'h0,   64'h0,    0, 64'h0,    2, 0, 1));

    drive(1, 1, 0, 0,0,0,0,0, 0, 64'h0, 64'h0, 0, 5'h0);
    repeat (2) @(posedge clk_i);

    // Table: one row per cycle, expectations queued at drive time
    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk_i); #1;
      e = tbl[i];
      drive(e.rst, e.emp, e.head, e.hl, e.st, e.mp, e.rw, e.cp, e.dest, e.res, e.ext, e.ack, 5'(i * 7));
      sb.push_back(e);
      @(negedge clk_i);
      e = sb.pop_front();
      chk($sformatf("row%0d updateHead", i), 64'(updateHead_o), 64'(e.uh));
      chk($sformatf("row%0d rfWriteEn", i), 64'(rfWriteEn_o), 64'(e.we));
      chk($sformatf("row%0d memReq", i), 64'(memReq_o), 64'(e.mreq));
      chk($sformatf("row%0d flush", i), 64'(flush_o), 64'(e.fl));
      chk($sformatf("row%0d halted", i), 64'(halted_o), 64'(e.hlt));
      chk($sformatf("row%0d retireTag", i), 64'(retireTag_o), 64'(e.tag));
      chk($sformatf("row%0d commitCount", i), 64'(commitCount_o), 64'(e.cnt));
      if (e.we || e.full) begin
        chk($sformatf("row%0d rfWriteAddr", i), 64'(rfWriteAddr_o), 64'(e.wa));
        chk($sformatf("row%0d rfWriteData", i), rfWriteData_o, e.wd);
      end
      if (e.mreq || e.full) begin
        chk($sformatf("row%0d memAddr", i), memAddr_o, e.ma);
        chk($sformatf("row%0d memData", i), memData_o, e.md);
      end
      if (e.fl || e.full) begin
        chk($sformatf("row%0d redirectPc", i), redirectPc_o, e.rpc);
      end
    end

    // Sustained back-to-back retires with random results
    for (int k = 0; k < 6; k++) begin
      @(posedge clk_i); #1;
      rv = {$urandom, $urandom};
      drive(0, 0, 5'(3 + k), 0,0,0,1,1, 5'(10 + k), rv, 64'h0, 0, 5'h1F);
      @(negedge clk_i);
      chk($sformatf("b2b%0d updateHead", k), 64'(updateHead_o), 64'd1);
      chk($sformatf("b2b%0d rfWriteAddr", k), 64'(rfWriteAddr_o), 64'(10 + k));
      chk($sformatf("b2b%0d rfWriteData", k), rfWriteData_o, rv);
    end
    @(posedge clk_i); #1;
    drive(0, 1, 5'd9, 0,0,0,0,0, 0, 64'h0, 64'h0, 0, 5'h0);
    @(negedge clk_i);
    chk("b2b commitCount", 64'(commitCount_o), 64'd7);
    chk("b2b retireTag", 64'(retireTag_o), 64'd8);

    // Store handshake with a bounded wait for the request
    @(posedge clk_i); #1;
    drive(0, 0, 5'd9, 0,1,0,0,1, 0, 64'h500, 64'h600, 0, 5'h0);
    seen = 1'b0;
    for (int w = 0; w < 8; w++) begin
      @(negedge clk_i);
      if (memReq_o) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk_i); #1;
    end
    chk("storeB request seen", 64'(seen), 64'd1);
    @(posedge clk_i); #1;
    memAck_i = 1'b1;
    @(negedge clk_i);
    chk("storeB updateHead on ack", 64'(updateHead_o), 64'd1);
    chk("storeB memAddr", memAddr_o, 64'h500);
    chk("storeB memData", memData_o, 64'h600);
    chk("storeB rfWriteEn", 64'(rfWriteEn_o), 64'd0);
    @(posedge clk_i); #1;
    drive(0, 1, 5'd10, 0,0,0,0,0, 0, 64'h0, 64'h0, 0, 5'h0);
    @(negedge clk_i);
    chk("storeB memReq drop", 64'(memReq_o), 64'd0);
    chk("storeB commitCount", 64'(commitCount_o), 64'd8);
    chk("storeB retireTag", 64'(retireTag_o), 64'd9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
